// File: rtl/common_def.sv
// Shared RV32I decode constants and the hazard sequencer's shadow-slot and cause types.
package common_def;

  localparam logic [6:0] BRANCH_opcode = 7'b1100011;
  localparam logic [6:0] JALR_opcode   = 7'b1100111;
  localparam logic [6:0] LOAD_opcode   = 7'b0000011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } shadow_slot_t;

  localparam shadow_slot_t SLOT_EMPTY = '0;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ALU_BR   = 2'd1,
    CAUSE_LOAD_BR  = 2'd2,
    CAUSE_LOAD_USE = 2'd3
  } hazard_cause_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FREEZE = 1'b1
  } seq_state_e;

  // Branches and JALR both resolve in decode, so both need their operands early.
  function automatic logic is_branch_op(input logic [6:0] opcode);
    return (opcode == BRANCH_opcode) || (opcode == JALR_opcode);
  endfunction

endpackage

// File: rtl/hazard_slot_match.sv
// Combinational check of one downstream shadow slot against the decode source registers.
module hazard_slot_match
  import common_def::*;
(
  input  shadow_slot_t slot_i,
  input  logic [4:0]   rs1_i,
  input  logic [4:0]   rs2_i,
  output logic         match_o
);

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  assign match_o = slot_i.valid && slot_i.we && (slot_i.rd != 5'd0) &&
                   ((slot_i.rd == rs1_i) || (slot_i.rd == rs2_i));

endmodule

// File: rtl/branch_hazard_sequencer.sv
// Decode-stage stall/bubble/flush sequencer: tracks EX/MEM producers, honours memory
// freezes and defers flushes that arrive while the pipeline is frozen.
module branch_hazard_sequencer
  import common_def::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_reg_we,
  input  logic              mem_busy,
  input  logic              branch_taken,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic              freeze_all,
  output logic [1:0]        hazard_cause,
  output logic [PERF_W-1:0] stall_count,
  output logic [PERF_W-1:0] flush_count
);

  shadow_slot_t      ex_q, ex_d, mem_q, mem_d;
  seq_state_e        state_q, state_d;
  logic              pend_flush_q, pend_flush_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  hazard_cause_e     cause;
  logic              ex_match, mem_match;
  logic              id_branch, id_load;
  logic              frozen, hazard, flush;
  logic              unused_instr_bits;

  assign id_branch         = is_branch_op(id_instr[6:0]);
  assign id_load           = (id_instr[6:0] == LOAD_opcode);
  assign unused_instr_bits = ^id_instr[31:12];

  hazard_slot_match u_ex_match (
    .slot_i  (ex_q),
    .rs1_i   (id_rs1),
    .rs2_i   (id_rs2),
    .match_o (ex_match)
  );

  hazard_slot_match u_mem_match (
    .slot_i  (mem_q),
    .rs1_i   (id_rs1),
    .rs2_i   (id_rs2),
    .match_o (mem_match)
  );

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    cause = CAUSE_NONE;
    if (id_valid) begin
      if (id_branch && ex_match) begin
        cause = ex_q.is_load ? CAUSE_LOAD_BR : CAUSE_ALU_BR;
      end else if (id_branch && mem_match && mem_q.is_load) begin
        cause = CAUSE_LOAD_BR;
      end else if (!id_branch && ex_match && ex_q.is_load) begin
        cause = CAUSE_LOAD_USE;
      end
    end
  end

  // The freeze takes effect in the very cycle mem_busy rises, not one cycle later.
  always_comb begin
    state_d = state_q;
    frozen  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          state_d = ST_FREEZE;
          frozen  = 1'b1;
        end
      end
      ST_FREEZE: begin
        if (mem_busy) frozen  = 1'b1;
        else          state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign hazard = (cause != CAUSE_NONE) && !frozen;
  assign flush  = !frozen && !hazard && (branch_taken || pend_flush_q);

  always_comb begin
    ex_d         = ex_q;
    mem_d        = mem_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pend_flush_d = pend_flush_q;

    if (!frozen) begin
      mem_d = ex_q;
      if (hazard || !id_valid) begin
        ex_d = SLOT_EMPTY;
      end else begin
        ex_d.valid   = 1'b1;
        ex_d.rd      = id_instr[11:7];
        ex_d.we      = id_reg_we;
        ex_d.is_load = id_load;
      end
      if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
      if (flush  && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + PERF_W'(1);
    end

    // A redirect seen during a freeze is remembered and replayed once memory is ready.
    if (frozen && branch_taken && (cause == CAUSE_NONE)) begin
      pend_flush_d = 1'b1;
    end else if (flush) begin
      pend_flush_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= SLOT_EMPTY;
      mem_q        <= SLOT_EMPTY;
      state_q      <= ST_RUN;
      pend_flush_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign freeze_all   = frozen && !rst;
  assign stall_pc     = hazard && !rst;
  assign stall_ifid   = hazard && !rst;
  assign bubble_idex  = hazard && !rst;
  assign flush_ifid   = flush  && !rst;
  assign hazard_cause = rst ? CAUSE_NONE : cause;
  assign stall_count  = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_branch_hazard_sequencer.sv
// Scoreboard bench: a driver predicts each cycle's outputs from a history-based model,
// a monitor pops and compares them against the sequencer mid-cycle.
module tb_branch_hazard_sequencer;

  localparam int          PW       = 4;
  localparam int unsigned CNT_MAX  = (1 << PW) - 1;
  localparam logic [6:0]  OPC_LOAD = 7'b0000011;
  localparam logic [6:0]  OPC_BR   = 7'b1100011;
  localparam logic [6:0]  OPC_JALR = 7'b1100111;
  localparam logic [6:0]  OPC_OP   = 7'b0110011;
  localparam logic [6:0]  OPC_IMM  = 7'b0010011;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [4:0]    id_rs1, id_rs2;
  logic          id_reg_we, mem_busy, branch_taken;
  logic          stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze_all;
  logic [1:0]    hazard_cause;
  logic [PW-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  branch_hazard_sequencer #(.PERF_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_reg_we    (id_reg_we),
    .mem_busy     (mem_busy),
    .branch_taken (branch_taken),
    .stall_pc     (stall_pc),
    .stall_ifid   (stall_ifid),
    .bubble_idex  (bubble_idex),
    .flush_ifid   (flush_ifid),
    .freeze_all   (freeze_all),
    .hazard_cause (hazard_cause),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  typedef struct {
    bit          v;
    int unsigned rd;
    bit          we;
    bit          ld;
  } op_t;

  typedef struct {
    bit          stall;
    bit          flush;
    bit          freeze;
    int unsigned cause;
    int unsigned sc;
    int unsigned fc;
  } exp_t;

  // hist[0] entered execute most recently, hist[1] the edge before that.
  op_t         hist[$];
  exp_t        sbq[$];
  int unsigned m_sc, m_fc;
  bit          m_pend;
  bit          last_hold;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hits(input op_t p, input int unsigned rs1, input int unsigned rs2);
    return p.v && p.we && (p.rd != 0) && ((p.rd == rs1) || (p.rd == rs2));
  endfunction

  function automatic int unsigned model_cause(input bit v, input logic [6:0] op,
                                              input int unsigned rs1, input int unsigned rs2);
    bit br;
    br = (op == OPC_BR) || (op == OPC_JALR);
    if (!v) return 0;
    if (br) begin
      if (hits(hist[0], rs1, rs2)) return hist[0].ld ? 2 : 1;
      if (hits(hist[1], rs1, rs2) && hist[1].ld) return 2;
      return 0;
    end
    if (hits(hist[0], rs1, rs2) && hist[0].ld) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    op_t e;
    e = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
    hist = {};
    hist.push_back(e);
    hist.push_back(e);
    m_sc   = 0;
    m_fc   = 0;
    m_pend = 1'b0;
  endtask

  task automatic step(input bit r, input bit v, input logic [6:0] op, input int unsigned rd,
                      input int unsigned rs1, input int unsigned rs2, input bit we,
                      input bit busy, input bit taken);
    exp_t        e;
    op_t         n;
    int unsigned c;
    bit          hz, fl;
    @(negedge clk);
    rst          = r;
    id_valid     = v;
    id_instr     = {20'b0, 5'(rd), op};
    id_rs1       = 5'(rs1);
    id_rs2       = 5'(rs2);
    id_reg_we    = we;
    mem_busy     = busy;
    branch_taken = taken;

    c  = model_cause(v, op, rs1, rs2);
    hz = !r && !busy && (c != 0);
    fl = !r && !busy && !hz && (taken || m_pend);
    e.stall  = hz;
    e.flush  = fl;
    e.freeze = !r && busy;
    e.cause  = r ? 0 : c;
    e.sc     = m_sc;
    e.fc     = m_fc;
    sbq.push_back(e);
    last_hold = hz || (busy && !r);

    if (r) begin
      model_reset();
    end else if (busy) begin
      if (taken && (c == 0)) m_pend = 1'b1;
    end else begin
      if (fl) m_pend = 1'b0;
      if (hz && (m_sc != CNT_MAX)) m_sc++;
      if (fl && (m_fc != CNT_MAX)) m_fc++;
      n.v  = v && !hz;
      n.rd = rd;
      n.we = we;
      n.ld = (op == OPC_LOAD);
      hist.push_front(n);
      void'(hist.pop_back());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, OPC_OP, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("stall_pc",     stall_pc,     e.stall);
        check("stall_ifid",   stall_ifid,   e.stall);
        check("bubble_idex",  bubble_idex,  e.stall);
        check("flush_ifid",   flush_ifid,   e.flush);
        check("freeze_all",   freeze_all,   e.freeze);
        check("hazard_cause", hazard_cause, e.cause);
        check("stall_count",  stall_count,  e.sc);
        check("flush_count",  flush_count,  e.fc);
      end
    end
  end

  initial begin : driver
    bit          v, we, busy, taken, r;
    logic [6:0]  op;
    int unsigned rd, rs1, rs2;
    logic [6:0]  opcs [5];
    opcs = '{OPC_LOAD, OPC_BR, OPC_JALR, OPC_OP, OPC_IMM};

    rst = 1'b1; id_valid = 1'b0; id_instr = '0; id_rs1 = '0; id_rs2 = '0;
    id_reg_we = 1'b0; mem_busy = 1'b0; branch_taken = 1'b0;
    model_reset();
    @(posedge clk);
    step(1, 0, OPC_OP, 0, 0, 0, 0, 0, 0);
    step(1, 0, OPC_OP, 0, 0, 0, 0, 0, 0);

    // load -> branch via EX then MEM slot: two stall cycles
    step(0, 1, OPC_LOAD, 5, 1, 0, 1, 0, 0);
    repeat (3) step(0, 1, OPC_BR, 0, 5, 6, 0, 0, 0);
    idle(2);
    // ALU -> JALR: one stall; producer writing x0 never stalls
    step(0, 1, OPC_OP, 7, 1, 2, 1, 0, 0);
    repeat (2) step(0, 1, OPC_JALR, 0, 7, 0, 0, 0, 0);
    idle(2);
    step(0, 1, OPC_OP, 0, 1, 2, 1, 0, 0);
    step(0, 1, OPC_JALR, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load -> use, and load, nop, branch hitting the MEM slot
    step(0, 1, OPC_LOAD, 3, 1, 0, 1, 0, 0);
    repeat (2) step(0, 1, OPC_OP, 4, 3, 1, 1, 0, 0);
    idle(2);
    step(0, 1, OPC_LOAD, 3, 1, 0, 1, 0, 0);
    step(0, 1, OPC_IMM, 0, 0, 0, 1, 0, 0);
    repeat (2) step(0, 1, OPC_BR, 0, 3, 2, 0, 0, 0);
    idle(2);
    // freeze in the middle of a load -> branch stall
    step(0, 1, OPC_LOAD, 5, 1, 0, 1, 0, 0);
    step(0, 1, OPC_BR, 0, 5, 6, 0, 0, 0);
    repeat (3) step(0, 1, OPC_BR, 0, 5, 6, 0, 1, 0);
    repeat (2) step(0, 1, OPC_BR, 0, 5, 6, 0, 0, 0);
    idle(2);
    // taken branch during a freeze: flush deferred to the first free cycle
    repeat (2) step(0, 1, OPC_BR, 0, 1, 2, 0, 1, 1);
    step(0, 0, OPC_OP, 0, 0, 0, 0, 0, 0);
    idle(2);
    // reset during the second stall cycle; the same branch then proceeds freely
    step(0, 1, OPC_LOAD, 5, 1, 0, 1, 0, 0);
    step(0, 1, OPC_BR, 0, 5, 6, 0, 0, 0);
    step(1, 1, OPC_BR, 0, 5, 6, 0, 0, 0);
    step(0, 1, OPC_BR, 0, 5, 6, 0, 0, 1);
    idle(2);

    // random traffic; decode holds its instruction while stalled or frozen
    v = 0; op = OPC_OP; rd = 0; rs1 = 0; rs2 = 0; we = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_hold) begin
        v   = ($urandom % 8) != 0;
        op  = opcs[$urandom % 5];
        rd  = $urandom % 4;
        rs1 = $urandom % 4;
        rs2 = $urandom % 4;
        we  = (op == OPC_BR) ? (($urandom % 4) == 0) : 1'b1;
      end
      busy  = ($urandom % 100) < 15;
      taken = v && ((op == OPC_BR) || (op == OPC_JALR)) && ($urandom % 2 == 1);
      r     = ($urandom % 300) == 0;
      step(r, v, op, rd, rs1, rs2, we, busy, taken);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
